// File: rtl/vmem_reader_pkg.sv
// Shared definitions for the vector memory reader.
// Lane geometry and FSM state encoding.
package vmem_reader_pkg;

  localparam int VEC_W_DEF  = 128;
  localparam int WORD_W_DEF = 32;
  localparam int LANES_DEF  = VEC_W_DEF / WORD_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } vmr_state_t;

  function automatic int lane_count(input int v, input int n);
    return v / n;
  endfunction

  function automatic int lane_idx_w(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

endpackage

// File: rtl/vmem_reader_lane_buffer.sv
// Vector assembly buffer: one N-bit slot per lane,
// written by a one-hot lane select.
module vlane_buffer #(
  parameter int V = 128,
  parameter int N = 32,
  parameter int L = V / N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [L-1:0] we,
  input  logic [N-1:0] wdata,
  output logic [V-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (we[k]) q[k*N +: N] <= wdata;
      end
    end
  end

endmodule

// File: rtl/vmem_reader.sv
// Multi-cycle vector load: fetches L words from data
// memory into a lane buffer and strobes write-back.
module vmem_reader
  import vmem_reader_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_M,
  input  logic [N-1:0] addr_M,
  input  logic [M-1:0] regScr_M,
  output logic         mem_ren,
  output logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_rvalid,
  output logic         stall,
  output logic         regw_M,
  output logic [M-1:0] regScr_out,
  output logic [V-1:0] regVrslt_M
);

  localparam int L  = lane_count(V, N);
  localparam int LW = lane_idx_w(L);
  localparam logic [LW-1:0] LAST  = LW'(L - 1);
  localparam logic [N-1:0]  BYTES = N'(N / 8);

  vmr_state_t    state;
  logic [LW-1:0] lane;
  logic [N-1:0]  base;
  logic [M-1:0]  idx;
  logic [L-1:0]  lane_we;
  logic          in_read;

  assign in_read = (state == READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lane   <= '0;
      base   <= '0;
      idx    <= '0;
      regw_M <= 1'b0;
    end else begin
      regw_M <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_M) begin
            base  <= addr_M;
            idx   <= regScr_M;
            lane  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (mem_rvalid) begin
            lane <= lane + LW'(1);
            if (lane == LAST) begin
              state  <= DONE;
              regw_M <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address wraps modulo 2^N by truncation of the adder.
  always_comb begin
    mem_ren  = in_read;
    mem_addr = '0;
    if (in_read) mem_addr = base + N'(lane) * BYTES;
  end

  always_comb begin
    lane_we = '0;
    if (in_read && mem_rvalid) lane_we[lane] = 1'b1;
  end

  assign stall = !rst &&
    ((state == IDLE && start_M) || in_read);

  assign regScr_out = idx;

  vlane_buffer #(
    .V(V),
    .N(N),
    .L(L)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (lane_we),
    .wdata(mem_rdata),
    .q    (regVrslt_M)
  );

endmodule

// File: tb/tb_vmem_reader.sv
// Directed bench for vmem_reader with a lane-level
// reference model checked every cycle.
module tb_vmem_reader;

  localparam int V = 128;
  localparam int N = 32;
  localparam int M = 4;
  localparam int L = V / N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_M = 1'b0;
  logic [N-1:0] addr_M = '0;
  logic [M-1:0] regScr_M = '0;
  logic         mem_ren;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic         stall;
  logic         regw_M;
  logic [M-1:0] regScr_out;
  logic [V-1:0] regVrslt_M;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_pulse = -1;
  int pulses = 0;
  logic [N-1:0] aq[$];

  vmem_reader #(.V(V), .N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_M   (start_M),
    .addr_M    (addr_M),
    .regScr_M  (regScr_M),
    .mem_ren   (mem_ren),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .stall     (stall),
    .regw_M    (regw_M),
    .regScr_out(regScr_out),
    .regVrslt_M(regVrslt_M)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a load is "busy" while words remain,
  // then a single pulse cycle, then idle again.
  logic         m_busy;
  logic         m_pulse;
  int           m_lane;
  logic [N-1:0] m_base;
  logic [M-1:0] m_idx;
  logic [N-1:0] m_vec[L];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_pulse <= 1'b0;
      m_lane  <= 0;
      m_base  <= '0;
      m_idx   <= '0;
      for (int k = 0; k < L; k++) m_vec[k] <= '0;
    end else begin
      m_pulse <= 1'b0;
      if (!m_busy && !m_pulse && start_M) begin
        m_busy <= 1'b1;
        m_lane <= 0;
        m_base <= addr_M;
        m_idx  <= regScr_M;
      end else if (m_busy && mem_rvalid) begin
        m_vec[m_lane] <= mem_rdata;
        m_lane <= m_lane + 1;
        if (m_lane == L - 1) begin
          m_busy  <= 1'b0;
          m_pulse <= 1'b1;
        end
      end
    end
  end

  function automatic logic [V-1:0] exp_vec();
    logic [V-1:0] v;
    for (int k = 0; k < L; k++) v[k*N +: N] = m_vec[k];
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [V-1:0] got,
                     input logic [V-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h",
               name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] ea;
    ea = m_busy ? m_base + N'(m_lane * (N / 8)) : '0;
    chk("mem_ren", V'(mem_ren), V'(m_busy));
    chk("mem_addr", V'(mem_addr), V'(ea));
    chk("stall", V'(stall),
        V'(!rst && (m_busy || (!m_pulse && start_M))));
    chk("regw_M", V'(regw_M), V'(m_pulse));
    chk("regScr_out", V'(regScr_out), V'(m_idx));
    chk("regVrslt_M", regVrslt_M, exp_vec());
    if (mem_ren && (aq.size() == 0 || aq[$] != mem_addr))
      aq.push_back(mem_addr);
    if (regw_M) begin
      last_pulse = cyc;
      pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N-1:0] a,
                      input logic [M-1:0] r,
                      input logic [V-1:0] dv,
                      input int waits,
                      input bit hijack,
                      output int lat);
    int t0;
    aq.delete();
    last_pulse = -1;
    start_M = 1'b1;
    addr_M = a;
    regScr_M = r;
    mem_rvalid = 1'b0;
    t0 = cyc;
    tick();
    start_M = 1'b0;
    for (int k = 0; k < L; k++) begin
      for (int w = 0; w < waits; w++) begin
        mem_rvalid = 1'b0;
        tick();
      end
      if (hijack && k == 1) begin
        start_M = 1'b1;
        addr_M = 32'h0000_0999;
        regScr_M = 4'd7;
      end
      mem_rvalid = 1'b1;
      mem_rdata = dv[k*N +: N];
      tick();
      start_M = 1'b0;
    end
    mem_rvalid = 1'b0;
    repeat (4) tick();
    lat = (last_pulse < 0) ? -1 : last_pulse - t0;
  endtask

  task automatic chk_addrs(input string name,
                           input logic [N-1:0] a0, a1, a2, a3);
    logic [N-1:0] e[4];
    e = '{a0, a1, a2, a3};
    chk({name, "_count"}, V'(aq.size()), V'(4));
    for (int i = 0; i < 4; i++)
      if (i < aq.size()) chk(name, V'(aq[i]), V'(e[i]));
  endtask

  int lat;
  int p0;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    chk("idle_vec", regVrslt_M, '0);
    chk("idle_pulses", V'(pulses), V'(0));

    load(32'h100, 4'd3,
         128'h00000044_00000033_00000022_00000011, 0, 0, lat);
    chk("b2b_lat", V'(lat), V'(5));
    chk("b2b_vec", regVrslt_M,
        128'h00000044_00000033_00000022_00000011);
    chk("b2b_idx", V'(regScr_out), V'(3));
    chk_addrs("b2b_addr", 32'h100, 32'h104, 32'h108, 32'h10C);

    load(32'h400, 4'd5,
         128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, 2, 0, lat);
    chk("wait_lat", V'(lat), V'(13));
    chk("wait_vec", regVrslt_M,
        128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    chk_addrs("wait_addr", 32'h400, 32'h404, 32'h408, 32'h40C);

    load(32'hFFFF_FFF8, 4'd9,
         128'h0000000D_0000000C_0000000B_0000000A, 0, 0, lat);
    chk("wrap_lat", V'(lat), V'(5));
    chk_addrs("wrap_addr", 32'hFFFF_FFF8, 32'hFFFF_FFFC,
              32'h0, 32'h4);

    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_DEAD;
    repeat (3) tick();
    mem_rvalid = 1'b0;
    chk("spur_vec", regVrslt_M,
        128'h0000000D_0000000C_0000000B_0000000A);

    load(32'h500, 4'd2,
         128'h50000004_50000003_50000002_50000001, 0, 1, lat);
    chk("hijack_lat", V'(lat), V'(5));
    chk("hijack_idx", V'(regScr_out), V'(2));
    chk_addrs("hijack_addr", 32'h500, 32'h504, 32'h508, 32'h50C);
    repeat (3) tick();

    p0 = pulses;
    start_M = 1'b1;
    addr_M = 32'h300;
    regScr_M = 4'd6;
    tick();
    start_M = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h3333_0001;
    tick();
    mem_rdata = 32'h3333_0002;
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b0;
    #2;
    chk("abort_vec_now", regVrslt_M, '0);
    chk("abort_ren_now", V'(mem_ren), V'(0));
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_pulses", V'(pulses), V'(p0));
    chk("abort_vec", regVrslt_M, '0);
    chk("abort_idx", V'(regScr_out), V'(0));

    load(32'h200, 4'd1,
         128'h20000004_20000003_20000002_20000001, 0, 0, lat);
    chk("fresh_lat", V'(lat), V'(5));
    chk("fresh_vec", regVrslt_M,
        128'h20000004_20000003_20000002_20000001);
    chk_addrs("fresh_addr", 32'h200, 32'h204, 32'h208, 32'h20C);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmem_reader.md
VMEM_READER -- requirements
Module: vmem_reader

Interface
REQ-001 SHALL have parameter V, default 128: vector register width in bits.
REQ-002 SHALL have parameter N, default 32: scalar word and memory data width in bits.
REQ-003 SHALL have parameter M, default 4: register-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start_M  input  1  vector-load request from Memory stage.
REQ-007 SHALL have port addr_M  input  N  byte base address of the vector.
REQ-008 SHALL have port regScr_M  input  M  destination vector register index.
REQ-009 SHALL have port mem_ren  output  1  data-memory read enable.
REQ-010 SHALL have port mem_addr  output  N  data-memory byte address.
REQ-011 SHALL have port mem_rdata  input  N  data-memory read word.
REQ-012 SHALL have port mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-013 SHALL have port stall  output  1  freeze upstream pipeline registers.
REQ-014 SHALL have port regw_M  output  1  one-cycle vector write-back strobe toward the Memory-Writeback pipeline.
REQ-015 SHALL have port regScr_out  output  M  latched destination index.
REQ-016 SHALL have port regVrslt_M  output  V  assembled vector toward the Memory-Writeback pipeline.

Function
REQ-017 SHALL have L = V/N lanes (4 at defaults); lane k occupies bits [k*N+N-1 : k*N].
REQ-018 SHALL implement FSM IDLE, READ, DONE.
REQ-019 IDLE: start_M=1 SHALL latch addr_M and regScr_M, clear the lane counter, and move to READ; otherwise the FSM SHALL stay in IDLE.
REQ-020 READ: mem_ren SHALL be 1, and mem_addr SHALL equal base + lane*(N/8), computed modulo 2^N (wrap-around permitted).
REQ-021 READ: on mem_rvalid=1, mem_rdata SHALL be written into the current lane and the lane counter SHALL increment; with mem_rvalid=0 the FSM SHALL hold its state, address and lane (variable memory latency).
REQ-022 READ: mem_rvalid=1 on lane L-1 SHALL move the FSM to DONE.
REQ-023 DONE: regw_M SHALL be 1 for exactly one cycle, regVrslt_M SHALL hold the full vector, and the FSM SHALL return to IDLE next cycle.
REQ-024 stall SHALL be combinational: 1 when (IDLE and start_M) or in READ, else 0.
REQ-025 start_M while in READ or DONE SHALL be ignored (upstream is stalled).
REQ-026 mem_rvalid in IDLE or DONE SHALL be ignored; no buffer change.
REQ-027 Minimum latency with mem_rvalid tied high SHALL be L+1 cycles from start_M to the regw_M pulse.
REQ-028 regVrslt_M and regScr_out SHALL hold their values after DONE until the next start_M.
REQ-029 Outside READ, mem_ren SHALL be 0 and mem_addr SHALL be 0.

Reset
REQ-030 rst SHALL immediately force IDLE, lane counter 0, lane buffer 0, latched base and index 0.
REQ-031 During reset, mem_ren, stall and regw_M SHALL be 0, and regVrslt_M and regScr_out SHALL be 0.
REQ-032 rst asserted mid-READ or in DONE SHALL abort with no regw_M pulse; the first cycle after release SHALL be IDLE.

Structure
REQ-033 The lane count L and the FSM state enum SHALL live in the shared processor package.
REQ-034 Per-lane storage SHALL be one sub-module, vlane_buffer, which is V bits wide with a lane-select write enable and asynchronous reset.
REQ-035 All other logic (FSM, counter, address adder) SHALL be flat within vmem_reader.

Verification
REQ-036 Reset-then-idle: rst pulse, no start -> all outputs 0 and stall 0 for 10 cycles.
REQ-037 Back-to-back: mem_rvalid=1, start_M with addr_M=0x100 and regScr_M=3 -> mem_addr 0x100, 0x104, 0x108, 0x10C; rdata 11,22,33,44 -> regVrslt_M={44,33,22,11}, regw_M pulse at cycle 5, regScr_out=3.
REQ-038 Wait states: mem_rvalid low 2 cycles before each word -> mem_addr held during waits, stall high throughout READ, regw_M pulse at cycle 13.
REQ-039 Address wrap: addr_M=0xFFFFFFF8 -> mem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-040 Abort: rst asserted after lane 1 is captured -> no regw_M pulse and zeroed buffer; a following load to 0x200 completes with fresh data only.
REQ-041 Spurious and ignored inputs: mem_rvalid=1 in IDLE with rdata=0xDEAD -> buffer unchanged; start_M asserted during READ -> no restart, base address unchanged.
